// File: rtl/io_page_uart_fifo.sv
// io_page_uart_fifo: IO page with LED register, FIFO-buffered UART TX, sticky overflow and cycle counter
// clk/reset: system clock, synchronous active-high reset
// IO_mem_addr/IO_mem_wdata/IO_mem_wr: CPU IO bus, 1-hot word address in IO_mem_addr[15:2]
// IO_mem_rdata: combinational OR of all selected registers
// LEDS: LED register, TXD: UART serial out (idle high)
module io_page_uart_fifo #(
    parameter int CLK_FREQ_HZ = 160000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 16,
    parameter int NB_LEDS     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        IO_mem_addr,
    input  logic [31:0]        IO_mem_wdata,
    input  logic               IO_mem_wr,
    output logic [31:0]        IO_mem_rdata,
    output logic [NB_LEDS-1:0] LEDS,
    output logic               TXD
);
    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DW  = $clog2(DIV);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [NB_LEDS-1:0] leds_q, leds_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ovf_q, ovf_d, txd_q, txd_d;
    logic [8:0]         sh_q, sh_d;
    logic [3:0]         bit_q, bit_d;
    logic [DW-1:0]      div_q, div_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [3:0]         sel;
    logic               wr_led, wr_dat, wr_cntl, full, empty, push, pop, txidle;
    logic [8:0]         cnt9;
    logic [7:0]         level;
    logic               unused_ok;

    assign unused_ok = ^{IO_mem_addr, IO_mem_wdata};
    assign LEDS = leds_q;
    assign TXD  = txd_q;

    always_comb begin
        sel       = IO_mem_addr[5:2];
        wr_led    = IO_mem_wr & sel[0];
        wr_dat    = IO_mem_wr & sel[1];
        wr_cntl   = IO_mem_wr & sel[2];
        full      = count_q == (AW+1)'(FIFO_DEPTH);
        empty     = count_q == '0;
        pop       = state_q == IDLE && !empty;
        // full is judged before this edge's pop, so a write to a full FIFO drops even while it drains
        push      = wr_dat & !full;
        txidle    = empty && state_q == IDLE;
        leds_d    = wr_led ? IO_mem_wdata[NB_LEDS-1:0] : leds_q;
        wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d     = (wr_dat & full) | (ovf_q & ~(wr_cntl & IO_mem_wdata[10]));
        cyc_d     = cyc_q + 32'd1;
        state_d   = state_q;
        txd_d     = txd_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        div_d     = div_q;
        if (pop) begin
            state_d = SHIFT;
            txd_d   = 1'b0;
            sh_d    = {1'b1, mem_q[rptr_q]};
            bit_d   = '0;
            div_d   = '0;
        end else if (state_q == SHIFT) begin
            // the stop bit's last cycle is spent in IDLE so a queued byte starts without a gap
            if (bit_q == 4'd9 && div_q == DW'(DIV-2)) begin
                state_d = IDLE;
            end else if (div_q == DW'(DIV-1)) begin
                div_d = '0;
                bit_d = bit_q + 4'd1;
                txd_d = sh_q[0];
                sh_d  = {1'b1, sh_q[8:1]};
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        cnt9         = 9'(count_q);
        level        = cnt9[8] ? 8'hff : cnt9[7:0];
        IO_mem_rdata = (sel[0] ? 32'(leds_q) : 32'd0)
                     | (sel[2] ? {21'd0, ovf_q, full, txidle, level} : 32'd0)
                     | (sel[3] ? cyc_q : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            leds_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            txd_q   <= 1'b1;
            sh_q    <= '1;
            bit_q   <= '0;
            div_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            txd_q   <= txd_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            cyc_q   <= cyc_d;
        end
    end
endmodule
